// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
//   sa_state_t    : controller states (IDLE, SHIFT, DONE)
//   SA_WIDTH      : default operand/result width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  localparam int SA_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// 1-bit full-adder cell: the only arithmetic element of the serial adder.
//   a, b : operand bits
//   c    : carry in
//   s    : sum bit
//   co   : carry out
module full_adder
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ c;
  assign co = (a & b) | (c & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder. Loads two WIDTH-bit operands and a carry-in on an
// accepted start, pushes them LSB-first through one full-adder cell over
// WIDTH cycles, then registers sum/cout and pulses done for one cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : load request, honoured in IDLE and DONE only
//   a, b, cin: operands, captured on an accepted start
//   busy     : high while bits are being processed
//   done     : one-cycle pulse, sum/cout valid
//   sum, cout: registered result, held until the next completion
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, acc;
  logic             c_reg;
  logic [CNT_W-1:0] cnt;
  logic             cell_s, cell_co;
  logic             load, shift_en, last;

  full_adder u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (c_reg),
    .s  (cell_s),
    .co (cell_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // A start here chains straight into the next addition with no bubble.
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are decoded from the state register only, so they cannot glitch.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      if (load) begin
        a_sr  <= a;
        b_sr  <= b;
        c_reg <= cin;
        acc   <= '0;
        cnt   <= '0;
      end else if (shift_en) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        acc   <= {cell_s, acc[WIDTH-1:1]};
        c_reg <= cell_co;
        cnt   <= cnt + CNT_W'(1);
      end
      // The last cell output goes straight into the result, bypassing acc.
      if (last) begin
        sum  <= {cell_s, acc[WIDTH-1:1]};
        cout <= cell_co;
      end
    end
  end

endmodule
